data_ram: RTL and testbench
===========================

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 256, number of WIDTH-bit words; power of two, >= 2.
REQ-003 Parameter ADDR_W, default 32, byte-address width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req  input  1  access request, qualified by ready.
REQ-008 we  input  1  1 = store, 0 = load.
REQ-009 funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 addr  input  ADDR_W  byte address.
REQ-011 wr_data  input  WIDTH  store data, right-aligned (bits [7:0] for a byte).
REQ-012 ready  output  1  block accepts a request this cycle.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data holds load result.
REQ-014 rd_data  output  WIDTH  right-aligned, extended load result.
REQ-015 err  output  1  one-cycle pulse: previous accepted request rejected.

Function
REQ-016 States: INIT (clearing), IDLE (serving); a request is accepted only when req && ready in IDLE.
REQ-017 INIT writes zero to word 0..DEPTH-1, one word per cycle, ready=0; after word DEPTH-1 the next state is IDLE with ready=1.
REQ-018 Word index = addr[LB +: log2(DEPTH)], LB = log2(WIDTH/8); higher address bits ignored (wrap-around).
REQ-019 Byte offset = addr[LB-1:0]; store data is shifted to that lane and only lanes covered by the access size are written.
REQ-020 Store completes at the accepting clock edge; no rd_valid for stores.
REQ-021 Load: rd_valid=1 exactly one cycle after acceptance; data extracted from the addressed lanes, sign-extended for B/H/W, zero-extended for BU/HU/WU.
REQ-022 One request per cycle, back-to-back loads/stores accepted every IDLE cycle with no bubbles.
REQ-023 A load accepted the cycle after a store to the same word returns the stored data.
REQ-024 Misaligned access (H with addr[0]=1; W with addr[1:0]!=0; D with addr[2:0]!=0) SHALL not modify memory and SHALL pulse err one cycle after acceptance with rd_valid=0.
REQ-025 Illegal funct3 (111 always; 011/110 when WIDTH=32; 1xx with we=1) SHALL behave as REQ-024.
REQ-026 rd_data holds its last value between rd_valid pulses; on err it is unchanged.
REQ-027 rd_valid and err are never asserted together.

Reset
REQ-028 During rst: ready=0, rd_valid=0, err=0, rd_data=0, state INIT, clear pointer 0.
REQ-029 Reset asserted mid-operation cancels any pending rd_valid/err and restarts INIT from word 0.
REQ-030 Memory contents are defined only by INIT, not by rst itself.

Structure
REQ-031 Shared package piRISC_mem_pkg holds funct3 encodings and the state enum typedef.
REQ-032 Storage is one sub-module ram_array (WIDTH, DEPTH; per-byte write enable, synchronous read).
REQ-033 Lane alignment, extension and error detection reside in data_ram.

Verification
REQ-034 Release rst -> ready=0 for exactly 256 cycles, then 1; load W from 0x3FC returns 0x00000000.
REQ-035 SW 0xDEADBEEF @0x10; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF.
REQ-036 SB 0x5A @0x21 over word 0x11223344 @0x20; LW @0x20 -> 0x11225A44.
REQ-037 SW 0x1 @0x402 -> err next cycle, no rd_valid; LW @0x400 still returns prior content.
REQ-038 Wrap: SW 0xCAFEF00D @0x400 (DEPTH=256); LW @0x000 -> 0xCAFEF00D.
REQ-039 LW issued, rst asserted before rd_valid -> no rd_valid, ready=0, INIT restarts at word 0.

Source files
------------

// File: rtl/piRISC_mem_pkg.sv
// Shared definitions for the data memory: funct3 size/sign codes, controller states
// and the access-legality check used when a request is accepted.
package piRISC_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    // Unsigned codes are load-only; doubleword and WU only exist on a 64-bit datapath.
    function automatic logic accessOk(input logic [2:0] f3, input logic we,
                                      input logic [2:0] a, input logic is64);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !a[0];
            F3_W:    ok = (a[1:0] == 2'b00);
            F3_D:    ok = is64 && (a[2:0] == 3'b000);
            F3_BU:   ok = !we;
            F3_HU:   ok = !we && !a[0];
            F3_WU:   ok = !we && is64 && (a[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// Request/response bundle between a load/store unit (master) and data_ram (slave).
interface data_ram_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wr_data;
    logic              ready;
    logic              rd_valid;
    logic [WIDTH-1:0]  rd_data;
    logic              err;

    modport master (
        output req, we, funct3, addr, wr_data,
        input  ready, rd_valid, rd_data, err
    );

    modport slave (
        input  req, we, funct3, addr, wr_data,
        output ready, rd_valid, rd_data, err
    );
endinterface

// File: rtl/ram_array.sv
// Single-port word memory with per-byte write enables and a registered read port.
module ram_array #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 256,
    localparam int NB    = WIDTH / 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [NB-1:0]    i_be,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Read-before-write: a same-cycle read returns the old word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/data_ram.sv
// Byte-addressable data memory: clears itself after reset, then serves RISC-V style
// loads/stores with lane alignment, sign/zero extension and misalignment errors.
module data_ram
    import piRISC_mem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    data_ram_if.slave bus
);

    localparam int NB = WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    state_t           r_state, w_nextState;
    logic [AW-1:0]    r_clrPtr;
    logic             r_loadPend, r_errPend;
    logic [LB-1:0]    r_ldOff;
    logic [2:0]       r_ldF3;
    logic [WIDTH-1:0] r_rdHold;

    logic             w_accept, w_ok;
    logic [LB-1:0]    w_off;
    logic [AW-1:0]    w_wordIdx, w_ramAddr;
    logic [NB-1:0]    w_sizeMask, w_ramBe;
    logic [WIDTH-1:0] w_ramWdata, w_ramRdata, w_rdShift, w_ldData;
    logic             w_unusedAddrHi;

    assign bus.ready      = (r_state == ST_IDLE);
    assign w_accept       = bus.req && bus.ready;
    assign w_off          = bus.addr[LB-1:0];
    assign w_wordIdx      = bus.addr[LB +: AW];
    assign w_unusedAddrHi = ^bus.addr[ADDR_W-1:LB+AW];
    assign w_ok           = accessOk(bus.funct3, bus.we, bus.addr[2:0], WIDTH == 64);

    always_comb begin
        w_sizeMask = '0;
        case (bus.funct3[1:0])
            2'b00:   w_sizeMask = NB'(8'h01);
            2'b01:   w_sizeMask = NB'(8'h03);
            2'b10:   w_sizeMask = NB'(8'h0F);
            default: w_sizeMask = NB'(8'hFF);
        endcase
    end

    // The clear sequencer owns the RAM port during INIT; afterwards the request does.
    always_comb begin
        w_ramAddr  = w_wordIdx;
        w_ramBe    = '0;
        w_ramWdata = bus.wr_data << {w_off, 3'b000};
        if (r_state == ST_INIT) begin
            w_ramAddr  = r_clrPtr;
            w_ramBe    = '1;
            w_ramWdata = '0;
        end else if (w_accept && bus.we && w_ok) begin
            w_ramBe = w_sizeMask << w_off;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_INIT: if (r_clrPtr == AW'(DEPTH - 1)) w_nextState = ST_IDLE;
            ST_IDLE: w_nextState = ST_IDLE;
            default: w_nextState = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_clrPtr <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_INIT) begin
                r_clrPtr <= r_clrPtr + 1'b1;
            end
        end
    end

    // Offset and size of the accepted load are kept to decode the RAM word a cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loadPend <= 1'b0;
            r_errPend  <= 1'b0;
            r_ldOff    <= '0;
            r_ldF3     <= '0;
            r_rdHold   <= '0;
        end else begin
            r_loadPend <= w_accept && !bus.we && w_ok;
            r_errPend  <= w_accept && !w_ok;
            if (w_accept) begin
                r_ldOff <= w_off;
                r_ldF3  <= bus.funct3;
            end
            if (r_loadPend) begin
                r_rdHold <= w_ldData;
            end
        end
    end

    always_comb begin
        w_rdShift = w_ramRdata >> {r_ldOff, 3'b000};
        w_ldData  = w_rdShift;
        case (r_ldF3)
            F3_B:    w_ldData = WIDTH'($signed(w_rdShift[7:0]));
            F3_BU:   w_ldData = WIDTH'(w_rdShift[7:0]);
            F3_H:    w_ldData = WIDTH'($signed(w_rdShift[15:0]));
            F3_HU:   w_ldData = WIDTH'(w_rdShift[15:0]);
            F3_W:    w_ldData = WIDTH'($signed(w_rdShift[31:0]));
            F3_WU:   w_ldData = WIDTH'(w_rdShift[31:0]);
            default: w_ldData = w_rdShift;
        endcase
    end

    assign bus.rd_valid = r_loadPend;
    assign bus.err      = r_errPend;
    assign bus.rd_data  = r_loadPend ? w_ldData : r_rdHold;

    ram_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_be    (w_ramBe),
        .i_addr  (w_ramAddr),
        .i_wdata (w_ramWdata),
        .o_rdata (w_ramRdata)
    );

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: table of load/store vectors with a response scoreboard,
// plus hand-written init-timing, back-to-back and mid-operation reset sequences.
module tb_data_ram;
    import piRISC_mem_pkg::*;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expErr;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        logic        isErr;
        logic [31:0] data;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t scoreQ[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    data_ram_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    data_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input int id,
                               input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s #%0d: actual=0x%08h required=0x%08h", name, id, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic expErr,
                                   input logic [31:0] expData);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.expErr = expErr; v.expData = expData;
        return v;
    endfunction

    // Drives one request for exactly one accepting edge; leaves req high for back-to-back use.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic expErr,
                                 input logic [31:0] expData, input int id);
        int   waitCnt;
        exp_t e;
        waitCnt = 0;
        while (!bus.ready && waitCnt < 400) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!bus.ready) begin
            checkOutput("readyTimeout", id, 32'(bus.ready), 32'd1);
            return;
        end
        bus.req     = 1'b1;
        bus.we      = we;
        bus.funct3  = f3;
        bus.addr    = addr;
        bus.wr_data = wdata;
        if (expErr || !we) begin
            e.isErr = expErr;
            e.data  = expData;
            e.id    = id;
            scoreQ.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitInitDone(input int id);
        int cnt;
        cnt = 0;
        while (!bus.ready && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("initCycles", id, 32'(cnt), 32'd256);
    endtask

    // Response monitor: every rd_valid/err pulse must match the oldest expectation.
    initial begin
        logic [31:0] lastRd;
        exp_t        e;
        lastRd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lastRd = '0;
            end else if (bus.rd_valid || bus.err) begin
                if (bus.rd_valid && bus.err) checkOutput("validAndErr", -1, 32'd1, 32'd0);
                if (scoreQ.size() == 0) begin
                    checkOutput("unexpectedOutput", -1, {30'd0, bus.rd_valid, bus.err}, 32'd0);
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput("errFlag", e.id, 32'(bus.err), 32'(e.isErr));
                    if (e.isErr) checkOutput("rdDataHeldOnErr", e.id, bus.rd_data, lastRd);
                    else         checkOutput("loadData", e.id, bus.rd_data, e.data);
                end
                if (bus.rd_valid) lastRd = bus.rd_data;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wr_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetReady",   0, 32'(bus.ready),    32'd0);
        checkOutput("resetRdValid", 0, 32'(bus.rd_valid), 32'd0);
        checkOutput("resetErr",     0, 32'(bus.err),      32'd0);
        checkOutput("resetRdData",  0, bus.rd_data,       32'd0);
        rst = 1'b0;
        waitInitDone(0);

        vecs.push_back(mkVec(0, F3_W,  32'h3FC, 32'h0,        0, 32'h00000000));
        vecs.push_back(mkVec(1, F3_W,  32'h010, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mkVec(0, F3_B,  32'h013, 32'h0,        0, 32'hFFFFFFDE));
        vecs.push_back(mkVec(0, F3_BU, 32'h013, 32'h0,        0, 32'h000000DE));
        vecs.push_back(mkVec(0, F3_H,  32'h010, 32'h0,        0, 32'hFFFFBEEF));
        vecs.push_back(mkVec(0, F3_HU, 32'h012, 32'h0,        0, 32'h0000DEAD));
        vecs.push_back(mkVec(0, F3_B,  32'h010, 32'h0,        0, 32'hFFFFFFEF));
        vecs.push_back(mkVec(0, F3_BU, 32'h011, 32'h0,        0, 32'h000000BE));
        vecs.push_back(mkVec(1, F3_W,  32'h020, 32'h11223344, 0, 32'h0));
        vecs.push_back(mkVec(1, F3_B,  32'h021, 32'hFFFFFF5A, 0, 32'h0));
        vecs.push_back(mkVec(0, F3_W,  32'h020, 32'h0,        0, 32'h11225A44));
        vecs.push_back(mkVec(1, F3_W,  32'h400, 32'hAABBCCDD, 0, 32'h0));
        vecs.push_back(mkVec(1, F3_W,  32'h402, 32'h00000001, 1, 32'h0));
        vecs.push_back(mkVec(0, F3_W,  32'h400, 32'h0,        0, 32'hAABBCCDD));
        vecs.push_back(mkVec(1, F3_W,  32'h400, 32'hCAFEF00D, 0, 32'h0));
        vecs.push_back(mkVec(0, F3_W,  32'h000, 32'h0,        0, 32'hCAFEF00D));
        vecs.push_back(mkVec(0, F3_H,  32'h011, 32'h0,        1, 32'h0));
        vecs.push_back(mkVec(0, F3_W,  32'h012, 32'h0,        1, 32'h0));
        vecs.push_back(mkVec(0, F3_D,  32'h000, 32'h0,        1, 32'h0));
        vecs.push_back(mkVec(0, 3'b111, 32'h000, 32'h0,       1, 32'h0));
        vecs.push_back(mkVec(1, F3_BU, 32'h000, 32'h000000FF, 1, 32'h0));
        vecs.push_back(mkVec(0, F3_WU, 32'h000, 32'h0,        1, 32'h0));
        vecs.push_back(mkVec(0, F3_W,  32'h000, 32'h0,        0, 32'hCAFEF00D));
        vecs.push_back(mkVec(1, F3_H,  32'h032, 32'h1234BEEF, 0, 32'h0));
        vecs.push_back(mkVec(0, F3_W,  32'h030, 32'h0,        0, 32'hBEEF0000));
        vecs.push_back(mkVec(0, F3_HU, 32'h032, 32'h0,        0, 32'h0000BEEF));
        vecs.push_back(mkVec(0, F3_H,  32'h032, 32'h0,        0, 32'hFFFFBEEF));
        vecs.push_back(mkVec(1, F3_H,  32'h002, 32'h00007FFF, 0, 32'h0));
        vecs.push_back(mkVec(0, F3_W,  32'h000, 32'h0,        0, 32'h7FFFF00D));
        vecs.push_back(mkVec(0, F3_H,  32'h002, 32'h0,        0, 32'h00007FFF));
        vecs.push_back(mkVec(1, F3_B,  32'h003, 32'h00000080, 0, 32'h0));
        vecs.push_back(mkVec(0, F3_B,  32'h003, 32'h0,        0, 32'hFFFFFF80));
        vecs.push_back(mkVec(0, F3_W,  32'h800, 32'h0,        0, 32'h80FFF00D));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expErr, vecs[i].expData, i + 1);
        end
        idle(3);

        // Back-to-back burst of stores then loads, no idle cycles between requests.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, F3_W, 32'h80 + 32'(i * 4), 32'hA5000000 | 32'(i * 32'h00010101),
                          0, 32'h0, 100 + i);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, F3_W, 32'h80 + 32'(i * 4), 32'h0,
                          0, 32'hA5000000 | 32'(i * 32'h00010101), 110 + i);
        end
        idle(3);

        // Load accepted, then reset lands before its response is sampled.
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = F3_W; bus.addr = 32'h10; bus.wr_data = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req = 1'b0;
        #1;
        checkOutput("midResetRdValid", 200, 32'(bus.rd_valid), 32'd0);
        checkOutput("midResetReady",   200, 32'(bus.ready),    32'd0);
        checkOutput("midResetErr",     200, 32'(bus.err),      32'd0);
        checkOutput("midResetRdData",  200, bus.rd_data,       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitInitDone(201);
        applyStimulus(0, F3_W, 32'h010, 32'h0, 0, 32'h0, 202);
        applyStimulus(0, F3_W, 32'h000, 32'h0, 0, 32'h0, 203);
        applyStimulus(0, F3_W, 32'h3FC, 32'h0, 0, 32'h0, 204);
        applyStimulus(0, F3_W, 32'h084, 32'h0, 0, 32'h0, 205);
        idle(3);

        checkOutput("queueEmpty", 300, 32'(scoreQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
